// File: rtl/sdram_read_cache.sv
// Direct-mapped, write-through, one-word-per-line read cache in front of the SDRAM controller.
// A read is looked up one cycle after it is latched, so a hit completes two cycles after rw_req.
module sdram_read_cache #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        rw_req,
  input  logic        rw,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  output logic [31:0] read_data,
  output logic        data_valid,
  input  logic        flush,
  output logic [31:0] d_address,
  output logic        d_rw_req,
  output logic        d_rw,
  output logic [31:0] d_write_data,
  output logic [1:0]  d_size,
  input  logic [31:0] d_read_data,
  input  logic        d_data_valid,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP, RELEASE} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [1:0]  size;
  } req_t;

  state_t state, nxt;
  req_t   req;

  logic [31:0]         data_mem [0:LINES-1];
  logic [TAG_BITS-1:0] tag_mem  [0:LINES-1];
  logic [LINES-1:0]    valid;
  logic                flush_pend;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit, flush_now, fill_done;
  logic [31:0]           merged;

  assign idx       = req.addr[INDEX_BITS+1:2];
  assign tag       = req.addr[31:INDEX_BITS+2];
  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign flush_now = (state == IDLE) && (flush || flush_pend);
  assign fill_done = (state == FILL) && d_data_valid;
  assign data_valid = (state == RESP);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:        if (!flush_now && rw_req) nxt = LOOKUP;
      LOOKUP:      nxt = req.rw ? WRITE : (hit ? RESP : FILL);
      FILL, WRITE: if (d_data_valid) nxt = RESP;
      RESP:        nxt = RELEASE;
      RELEASE:     if (!rw_req) nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  always_comb begin
    d_rw_req     = 1'b0;
    d_rw         = 1'b0;
    d_address    = '0;
    d_write_data = '0;
    d_size       = '0;
    case (state)
      FILL: begin
        d_rw_req  = 1'b1;
        d_size    = 2'd2;
        d_address = {req.addr[31:2], 2'b00};
      end
      WRITE: begin
        d_rw_req     = 1'b1;
        d_rw         = req.rw;
        d_address    = req.addr;
        d_write_data = req.wdata;
        d_size       = req.size;
      end
      default: ;
    endcase
  end

  // Lane merge for write hits; misaligned accesses use the raw addr[1:0] lane.
  always_comb begin
    merged = data_mem[idx];
    case (req.size)
      2'd0: merged[{req.addr[1:0], 3'b000} +: 8] = req.wdata[7:0];
      2'd1: if (req.addr[1]) merged[31:16] = req.wdata[15:0];
            else             merged[15:0]  = req.wdata[15:0];
      default: merged = req.wdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req        <= '0;
      read_data  <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE) flush_pend <= 1'b0;
      else if (flush)    flush_pend <= 1'b1;
      if (flush_now)      valid      <= '0;
      else if (fill_done) valid[idx] <= 1'b1;
      if (state == IDLE && !flush_now && rw_req)
        req <= '{addr: address, rw: rw, wdata: write_data, size: size};
      if (state == LOOKUP && !req.rw) begin
        if (hit) begin
          read_data <= data_mem[idx];
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end else if (miss_count != 16'hFFFF) begin
          miss_count <= miss_count + 16'd1;
        end
      end
      if (fill_done) read_data <= d_read_data;
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx] <= d_read_data;
      tag_mem[idx]  <= tag;
    end else if (state == WRITE && d_data_valid && hit) begin
      data_mem[idx] <= merged;
    end
  end
endmodule

// File: tb/tb_sdram_read_cache.sv
// Directed bench for sdram_read_cache with a fixed-latency SDRAM responder.
module tb_sdram_read_cache;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic        rw_req = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] write_data = '0;
  logic [1:0]  size = '0;
  logic [31:0] read_data;
  logic        data_valid;
  logic        flush = 1'b0;
  logic [31:0] d_address;
  logic        d_rw_req;
  logic        d_rw;
  logic [31:0] d_write_data;
  logic [1:0]  d_size;
  logic [31:0] d_read_data;
  logic        d_data_valid;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_chk = 0;
  int n_fail = 0;

  sdram_read_cache dut (
    .clk(clk), .reset(reset), .address(address), .rw_req(rw_req), .rw(rw),
    .write_data(write_data), .size(size), .read_data(read_data),
    .data_valid(data_valid), .flush(flush), .d_address(d_address),
    .d_rw_req(d_rw_req), .d_rw(d_rw), .d_write_data(d_write_data),
    .d_size(d_size), .d_read_data(d_read_data), .d_data_valid(d_data_valid),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // SDRAM responder: records each request, answers 5 cycles later from mem.
  logic [31:0] mem [0:1023];
  int          req_cnt = 0;
  logic [31:0] last_addr = '0, last_wd = '0;
  logic [1:0]  last_size = '0;
  logic        last_rw = 1'b0;
  logic        busy;
  int          cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy         <= 1'b0;
      cnt          <= 0;
      d_data_valid <= 1'b0;
      d_read_data  <= '0;
    end else begin
      d_data_valid <= 1'b0;
      if (d_rw_req && !busy && !d_data_valid) begin
        busy      <= 1'b1;
        cnt       <= 5;
        req_cnt   <= req_cnt + 1;
        last_addr <= d_address;
        last_wd   <= d_write_data;
        last_size <= d_size;
        last_rw   <= d_rw;
      end else if (busy) begin
        if (cnt == 1) begin
          busy         <= 1'b0;
          d_data_valid <= 1'b1;
          d_read_data  <= last_rw ? 32'h0 : mem[last_addr[11:2]];
        end
        cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [1:0] sz, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    address = a; rw = w; write_data = wd; size = sz; rw_req = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (data_valid) break;
    end
    chk("acc_done", {31'b0, data_valid}, 32'd1);
    rd = read_data;
    rw_req = 1'b0;
    @(posedge clk); #1;
    chk("dv_pulse", {31'b0, data_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  int lat, r0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h30010 >> 2 & 1023] = 32'hDEADBEEF;
    mem[32'h30110 >> 2 & 1023] = 32'h12345678;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", {31'b0, data_valid}, 32'd0);
    chk("rst_dreq", {31'b0, d_rw_req}, 32'd0);
    chk("rst_hit", {16'b0, hit_count}, 32'd0);
    chk("rst_miss", {16'b0, miss_count}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    reset = 1'b1;

    // cold read
    r0 = req_cnt;
    acc(32'h30010, 1'b0, 0, 2'd0, rd, lat);
    chk("cold_rd", rd, 32'hDEADBEEF);
    chk("cold_req", req_cnt - r0, 32'd1);
    chk("cold_daddr", last_addr, 32'h30010);
    chk("cold_dsize", {30'b0, last_size}, 32'd2);
    chk("cold_drw", {31'b0, last_rw}, 32'd0);
    chk("cold_miss", {16'b0, miss_count}, 32'd1);

    // repeat read hits
    r0 = req_cnt;
    acc(32'h30010, 1'b0, 0, 2'd0, rd, lat);
    chk("hit_rd", rd, 32'hDEADBEEF);
    chk("hit_lat", lat, 32'd2);
    chk("hit_req", req_cnt - r0, 32'd0);
    chk("hit_cnt", {16'b0, hit_count}, 32'd1);

    // byte write through
    r0 = req_cnt;
    acc(32'h30012, 1'b1, 32'hAA, 2'd0, rd, lat);
    mem[32'h30010 >> 2 & 1023] = 32'hDEAABEEF;
    chk("bw_req", req_cnt - r0, 32'd1);
    chk("bw_daddr", last_addr, 32'h30012);
    chk("bw_dsize", {30'b0, last_size}, 32'd0);
    chk("bw_dwd", last_wd, 32'hAA);
    chk("bw_drw", {31'b0, last_rw}, 32'd1);
    chk("bw_cnts", {hit_count, miss_count}, {16'd1, 16'd1});
    acc(32'h30010, 1'b0, 0, 2'd0, rd, lat);
    chk("bw_rd", rd, 32'hDEAABEEF);
    chk("bw_hit", {16'b0, hit_count}, 32'd2);

    // half write, low lane
    acc(32'h30010, 1'b1, 32'h5566, 2'd1, rd, lat);
    mem[32'h30010 >> 2 & 1023] = 32'hDEAA5566;
    acc(32'h30010, 1'b0, 0, 2'd2, rd, lat);
    chk("hw_rd", rd, 32'hDEAA5566);
    chk("hw_hit", {16'b0, hit_count}, 32'd3);

    // index conflict
    r0 = req_cnt;
    acc(32'h30110, 1'b0, 0, 2'd2, rd, lat);
    chk("cf_rd0", rd, 32'h12345678);
    acc(32'h30010, 1'b0, 0, 2'd2, rd, lat);
    chk("cf_rd1", rd, 32'hDEAA5566);
    acc(32'h30110, 1'b0, 0, 2'd2, rd, lat);
    chk("cf_rd2", rd, 32'h12345678);
    chk("cf_req", req_cnt - r0, 32'd3);
    chk("cf_miss", {16'b0, miss_count}, 32'd4);

    // flush while idle
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    acc(32'h30110, 1'b0, 0, 2'd2, rd, lat);
    chk("fi_miss", {16'b0, miss_count}, 32'd5);

    // flush during an outstanding fill
    r0 = req_cnt;
    fork
      acc(32'h30010, 1'b0, 0, 2'd2, rd, lat);
      begin
        for (int k = 0; k < 50 && !d_rw_req; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    chk("ff_rd", rd, 32'hDEAA5566);
    chk("ff_miss", {16'b0, miss_count}, 32'd6);
    acc(32'h30010, 1'b0, 0, 2'd2, rd, lat);
    chk("ff_rd2", rd, 32'hDEAA5566);
    chk("ff_miss2", {16'b0, miss_count}, 32'd7);
    chk("ff_req", req_cnt - r0, 32'd2);

    // write miss does not allocate
    acc(32'h30020, 1'b1, 32'h11223344, 2'd2, rd, lat);
    mem[32'h30020 >> 2 & 1023] = 32'h11223344;
    acc(32'h30020, 1'b0, 0, 2'd2, rd, lat);
    chk("wm_miss", {16'b0, miss_count}, 32'd8);
    chk("wm_rd", rd, 32'h11223344);
    acc(32'h30020, 1'b0, 0, 2'd2, rd, lat);
    chk("wm_hit", {16'b0, hit_count}, 32'd4);

    // reset while in FILL
    @(posedge clk); #1;
    address = 32'h30200; rw = 1'b0; size = 2'd2; rw_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rf_dreq_on", {31'b0, d_rw_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rf_dreq", {31'b0, d_rw_req}, 32'd0);
    chk("rf_dv", {31'b0, data_valid}, 32'd0);
    chk("rf_cnts", {hit_count, miss_count}, 32'd0);
    rw_req = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    acc(32'h30010, 1'b0, 0, 2'd2, rd, lat);
    chk("rf_post_miss", {16'b0, miss_count}, 32'd1);
    chk("rf_post_rd", rd, 32'hDEAA5566);

    // hit counter saturation
    acc(32'h30010, 1'b0, 0, 2'd2, rd, lat);
    chk("sat_h1", {16'b0, hit_count}, 32'd1);
    force dut.hit_count = 16'hFFFE;
    #1;
    release dut.hit_count;
    acc(32'h30010, 1'b0, 0, 2'd2, rd, lat);
    chk("sat_ffff", {16'b0, hit_count}, 32'hFFFF);
    acc(32'h30010, 1'b0, 0, 2'd2, rd, lat);
    chk("sat_hold", {16'b0, hit_count}, 32'hFFFF);
    chk("sat_miss", {16'b0, miss_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
